led_scan_ctrl: RTL and testbench
================================

Name: led_scan_ctrl

Overview:
- Sequencer for the 4-digit multiplexed 7-segment display on the FP adder board.
- Holds a 32-bit adder result and time-multiplexes it one hex nibble at a time onto the shared hex-to-segment decoder.
- Drives the active-low digit anodes.
- Shows the lower or upper 16 bits as a "page", either auto-rotating or selected manually; new results are committed only at frame boundaries so the display never tears.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit is lit (min 2)
PAGE_FRAMES, 256, full 4-digit frames per page in auto mode (min 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
load  input  1  single-cycle strobe: capture value
value  input  32  FP result to display
auto_page  input  1  1 = pages alternate automatically; 0 = page_sel chooses
page_sel  input  1  manual page: 0 = bits[15:0], 1 = bits[31:16]
symbol  output  4  nibble to the segment decoder
an  output  4  digit anodes, active-low one-hot, an[0] = least significant digit
page  output  1  page currently shown
pending  output  1  a loaded value is waiting for the frame boundary

Behaviour:
- Reset (reset=0, async), all values:
  - div_cnt=0, digit=0, frame_cnt=0
  - shadow=0, disp=0, pending=0, page=0
  - an=4'b1110, symbol=0
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - tick = (div_cnt==REFRESH_DIV-1).
- Digit scan:
  - On tick, digit advances 0->1->2->3->0.
  - an = ~(4'b0001<<digit); exactly one anode low at all times out of reset.
- Frame boundary: tick while digit==3.
- Load path:
  - load=1 -> shadow<=value, pending<=1 next cycle.
  - Repeated loads while pending: last one wins.
- Commit: at a frame boundary with pending=1 -> disp<=shadow, pending<=0.
- Load coinciding with a boundary:
  - The old shadow is committed.
  - The new value goes to shadow, and pending stays 1 (set beats clear).
- Page control, auto_page=1:
  - frame_cnt increments at each boundary.
  - When frame_cnt==PAGE_FRAMES-1 at a boundary: frame_cnt<=0 and page toggles.
- Page control, auto_page=0:
  - page takes page_sel, sampled only at a frame boundary.
  - frame_cnt held at 0.
  - A page change therefore never happens mid-frame.
- Switching auto_page 0->1: counting starts from frame_cnt=0 and the current page.
- Output:
  - symbol = disp[page*16 + digit*4 +: 4], registered together with an so the two change on the same edge.
  - Latency: a digit change is visible 1 cycle after tick.
  - A committed value is visible starting with digit 0 of the next frame.
- Reset asserted mid-frame or with a load pending: everything is cleared immediately; the pending value is discarded.
- Unused nibbles are never output.
- load with X on value is outside the contract.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined:
  - On the current page, a digit is blanked (an=4'b1111 for its whole slot) if it and every more-significant nibble of that page are 0.
  - Digit 0 is never blanked, so 0x0000 shows a single "0".
  - Scan timing is unchanged.
- When undefined: all four digits are always lit, including leading zeros.

Test Plan:
1. Reset, REFRESH_DIV=4, PAGE_FRAMES=2, auto_page=1, no load -> an sequence 1110,1101,1011,0111 every 4 cycles, symbol=0, page toggles every 32 cycles, pending=0.
2. load value=32'h4049_0FDB mid-frame (digit=1) -> pending=1 next cycle; symbols stay 0 until the boundary; then the next frame shows digits B,D,F,0 (page 0); after the page toggle it shows 9,4,0,4; pending=0 after the commit.
3. load 32'h1111_1111 then 32'h2222_2222 in the same frame -> only 2 is ever shown; 1 never appears on symbol.
4. load 32'hAAAA_5555 on the exact boundary cycle while shadow=32'h3F80_0000 is pending -> next frame shows the 3F80_0000 nibbles, pending stays 1, and the following frame shows the AAAA_5555 nibbles.
5. auto_page=0; toggle page_sel 0->1 while digit=2 -> page and the upper-half nibbles change only after digit 3 completes.
6. reset pulsed low while digit=2 with pending=1 -> outputs return to their reset values asynchronously, and disp stays 0 after release. With LEADING_ZERO_BLANK_EN and disp=32'h0000_00A5 on page 0, an is 1111 during digits 3 and 2, and digits 1,0 show A,5.

Source files
------------

// File: rtl/led_scan_ctrl_if.sv
// Signal bundle between the FP adder result source and the 4-digit display sequencer.
interface led_scan_ctrl_if;
  logic        load;
  logic [31:0] value;
  logic        auto_page;
  logic        page_sel;
  logic [3:0]  symbol;
  logic [3:0]  an;
  logic        page;
  logic        pending;

  modport master (
    output load, value, auto_page, page_sel,
    input  symbol, an, page, pending
  );

  modport slave (
    input  load, value, auto_page, page_sel,
    output symbol, an, page, pending
  );
endinterface

// File: rtl/led_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan sequencer with frame-aligned result commit and paging.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits of the shown page.
module led_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned PAGE_FRAMES = 256
) (
  input logic            clk,
  input logic            reset,
  led_scan_ctrl_if.slave bus
);

  localparam int unsigned DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FW = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(PAGE_FRAMES - 1);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

  digit_e        r_digit;
  digit_e        w_digit_nxt;
  logic [DW-1:0] r_div_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic [FW-1:0] w_frame_nxt;
  logic [31:0]   r_shadow;
  logic [31:0]   r_disp;
  logic [31:0]   w_disp_nxt;
  logic          r_pending;
  logic          r_page;
  logic          w_page_nxt;
  logic [3:0]    r_symbol;
  logic [3:0]    r_an;
  logic [3:0]    w_symbol;
  logic [3:0]    w_an;
  logic [15:0]   w_half;
  logic [1:0]    w_dig_idx;
  logic          w_tick;
  logic          w_boundary;

  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_boundary = w_tick && (r_digit == DIG3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digit <= DIG0;
    end else begin
      r_digit <= w_digit_nxt;
    end
  end

  always_comb begin
    w_digit_nxt = r_digit;
    if (w_tick) begin
      unique case (r_digit)
        DIG0: w_digit_nxt = DIG1;
        DIG1: w_digit_nxt = DIG2;
        DIG2: w_digit_nxt = DIG3;
        DIG3: w_digit_nxt = DIG0;
      endcase
    end
  end

  // A load on the boundary cycle still commits the old shadow; set wins over clear.
  assign w_disp_nxt = (w_boundary && r_pending) ? r_shadow : r_disp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (bus.load) begin
        r_shadow <= bus.value;
      end
      r_disp    <= w_disp_nxt;
      r_pending <= bus.load | (r_pending & ~w_boundary);
    end
  end

  always_comb begin
    w_page_nxt  = r_page;
    w_frame_nxt = r_frame_cnt;
    if (!bus.auto_page) begin
      w_frame_nxt = '0;
      if (w_boundary) begin
        w_page_nxt = bus.page_sel;
      end
    end else if (w_boundary) begin
      if (r_frame_cnt == FRM_LAST) begin
        w_frame_nxt = '0;
        w_page_nxt  = ~r_page;
      end else begin
        w_frame_nxt = r_frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
      r_page      <= 1'b0;
    end else begin
      r_frame_cnt <= w_frame_nxt;
      r_page      <= w_page_nxt;
    end
  end

  // Outputs derive from next-state values so an/symbol land on the same edge as the digit step.
  assign w_dig_idx = w_digit_nxt;
  assign w_half    = w_page_nxt ? w_disp_nxt[31:16] : w_disp_nxt[15:0];

  always_comb begin
    w_symbol = w_half[{w_dig_idx, 2'b00} +: 4];
    w_an     = ~(4'b0001 << w_dig_idx);
`ifdef LEADING_ZERO_BLANK_EN
    unique case (w_dig_idx)
      2'd1:    if (w_half[15:4] == '0)  w_an = '1;
      2'd2:    if (w_half[15:8] == '0)  w_an = '1;
      2'd3:    if (w_half[15:12] == '0) w_an = '1;
      default: w_an = w_an;
    endcase
`else
    w_an = w_an;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_symbol <= '0;
      r_an     <= 4'b1110;
    end else begin
      r_symbol <= w_symbol;
      r_an     <= w_an;
    end
  end

  assign bus.symbol  = r_symbol;
  assign bus.an      = r_an;
  assign bus.page    = r_page;
  assign bus.pending = r_pending;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed scoreboard bench for led_scan_ctrl with REFRESH_DIV=4, PAGE_FRAMES=2.
module tb_led_scan_ctrl;

  localparam int unsigned RD = 4;
  localparam int unsigned PF = 2;

  typedef struct {
    int         e;
    logic [3:0] an;
    logic [3:0] sym;
    logic       pg;
    logic       pend;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   ncmp;
  int   nfail;
  exp_t sbq[$];

  led_scan_ctrl_if bus ();

  led_scan_ctrl #(.REFRESH_DIV(RD), .PAGE_FRAMES(PF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release: after edge e, digit = (e/4)%4 and frame = e/16.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [3:0] nib(logic [31:0] v, logic pg, int d);
    logic [15:0] h;
    logic [15:0] t;
    h = pg ? v[31:16] : v[15:0];
    t = h >> (d * 4);
    return t[3:0];
  endfunction

  function automatic logic [3:0] exp_an(logic [31:0] v, logic pg, int d);
    logic [15:0] h;
    logic [3:0]  a;
    h = pg ? v[31:16] : v[15:0];
    a = ~(4'b0001 << d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (h >> (d * 4)) == 16'h0) a = 4'b1111;
`else
    if (h === 16'hxxxx) a = 4'b1111;
`endif
    return a;
  endfunction

  task automatic push_range(int e0, int e1, logic [31:0] v, logic pg, logic pend);
    for (int e = e0; e <= e1; e++) begin
      exp_t x;
      int   d;
      d      = (e / RD) % 4;
      x.e    = e;
      x.an   = exp_an(v, pg, d);
      x.sym  = nib(v, pg, d);
      x.pg   = pg;
      x.pend = pend;
      sbq.push_back(x);
    end
  endtask

  task automatic chk(string tag, int e, logic [3:0] an_x, logic [3:0] sym_x,
                     logic pg_x, logic pend_x);
    ncmp++;
    assert (bus.an === an_x) else begin
      nfail++;
      $error("FAIL %s an e=%0d got %b expected %b", tag, e, bus.an, an_x);
    end
    ncmp++;
    assert (bus.symbol === sym_x) else begin
      nfail++;
      $error("FAIL %s symbol e=%0d got %h expected %h", tag, e, bus.symbol, sym_x);
    end
    ncmp++;
    assert (bus.page === pg_x) else begin
      nfail++;
      $error("FAIL %s page e=%0d got %b expected %b", tag, e, bus.page, pg_x);
    end
    ncmp++;
    assert (bus.pending === pend_x) else begin
      nfail++;
      $error("FAIL %s pending e=%0d got %b expected %b", tag, e, bus.pending, pend_x);
    end
  endtask

  task automatic run_to(string tag, int target);
    int guard;
    guard = 0;
    forever begin
      while (sbq.size() > 0 && sbq[0].e <= cyc) begin
        exp_t x;
        x = sbq.pop_front();
        if (x.e < cyc) begin
          ncmp++;
          nfail++;
          $display("FAIL %s sb_skip entry e=%0d at cyc %0d expected in order", tag, x.e, cyc);
        end else begin
          chk(tag, x.e, x.an, x.sym, x.pg, x.pend);
        end
      end
      if (cyc >= target) break;
      @(negedge clk);
      guard++;
      if (guard > 1000) begin
        ncmp++;
        nfail++;
        $display("FAIL %s timeout cyc=%0d expected to reach %0d", tag, cyc, target);
        break;
      end
    end
  endtask

  task automatic do_load(string tag, int at, logic [31:0] v);
    run_to(tag, at);
    bus.load  = 1'b1;
    bus.value = v;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  initial begin
    ncmp          = 0;
    nfail         = 0;
    reset         = 1'b0;
    bus.load      = 1'b0;
    bus.value     = '0;
    bus.auto_page = 1'b1;
    bus.page_sel  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", -1, 4'b1110, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;

    // idle scan, auto paging every 2 frames
    push_range(0, 31, 32'h0, 1'b0, 1'b0);
    push_range(32, 47, 32'h0, 1'b1, 1'b0);
    run_to("idle", 47);

    // mid-frame load commits at the boundary
    push_range(48, 53, 32'h0, 1'b1, 1'b0);
    push_range(54, 63, 32'h0, 1'b1, 1'b1);
    push_range(64, 95, 32'h4049_0FDB, 1'b0, 1'b0);
    push_range(96, 111, 32'h4049_0FDB, 1'b1, 1'b0);
    do_load("load", 53, 32'h4049_0FDB);
    run_to("load", 111);

    // last load before the boundary wins
    push_range(112, 113, 32'h4049_0FDB, 1'b1, 1'b0);
    push_range(114, 127, 32'h4049_0FDB, 1'b1, 1'b1);
    push_range(128, 159, 32'h2222_2222, 1'b0, 1'b0);
    do_load("lastwin", 113, 32'h1111_1111);
    do_load("lastwin", 117, 32'h2222_2222);
    run_to("lastwin", 159);

    // load on the boundary cycle keeps pending for one more frame
    push_range(160, 161, 32'h2222_2222, 1'b1, 1'b0);
    push_range(162, 175, 32'h2222_2222, 1'b1, 1'b1);
    push_range(176, 191, 32'h3F80_0000, 1'b1, 1'b1);
    push_range(192, 223, 32'hAAAA_5555, 1'b0, 1'b0);
    push_range(224, 235, 32'hAAAA_5555, 1'b1, 1'b0);
    do_load("bnd", 161, 32'h3F80_0000);
    do_load("bnd", 175, 32'hAAAA_5555);
    run_to("bnd", 235);

    // manual paging: page changes only at the frame boundary
    push_range(236, 239, 32'hAAAA_5555, 1'b1, 1'b0);
    push_range(240, 271, 32'hAAAA_5555, 1'b0, 1'b0);
    push_range(272, 303, 32'hAAAA_5555, 1'b1, 1'b0);
    bus.auto_page = 1'b0;
    bus.page_sel  = 1'b0;
    run_to("manual", 265);
    bus.page_sel = 1'b1;
    run_to("manual", 300);

    // back to auto: counting restarts from frame 0 on the current page
    bus.auto_page = 1'b1;
    push_range(304, 319, 32'hAAAA_5555, 1'b1, 1'b0);
    push_range(320, 337, 32'hAAAA_5555, 1'b0, 1'b0);
    push_range(338, 344, 32'hAAAA_5555, 1'b0, 1'b1);
    do_load("reauto", 337, 32'h1234_5678);
    run_to("reauto", 344);

    // async reset mid-frame with a pending value
    reset = 1'b0;
    #1;
    chk("async_rst", -1, 4'b1110, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", -1, 4'b1110, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    push_range(0, 31, 32'h0, 1'b0, 1'b0);
    push_range(32, 50, 32'h0, 1'b1, 1'b0);
    push_range(51, 63, 32'h0, 1'b1, 1'b1);
    push_range(64, 95, 32'h0000_00A5, 1'b0, 1'b0);
    push_range(96, 111, 32'h0000_00A5, 1'b1, 1'b0);
    do_load("post_rst", 50, 32'h0000_00A5);
    run_to("post_rst", 111);

    ncmp++;
    assert (sbq.size() == 0) else begin
      nfail++;
      $error("FAIL sb_leftover got %0d entries expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
